change_dispenser: RTL and testbench

- Transmit side of the vending coin interface. The vending FSM consumes coin codes on a 2-bit bus; this block drives the same encoding outward to the coin-return mechanism.
- The code encoding is 00 none, 01 Rs1, 10 Rs2, 11 Rs5.
- On a change request it breaks an amount into coins, largest denomination first, and emits one coin per handshake.
- It reports completion, or a shortfall if exact change cannot be made.

---
 rtl/change_dispenser.sv | 197 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
//   Transmit side of the vending coin interface. Breaks a change amount into
//   coins (largest denomination first) and hands them one at a time to the
//   coin-return mechanism, using the same 2-bit coin encoding as the vending
//   FSM: 00 none, 01 Rs1, 10 Rs2, 11 Rs5.
//
//   Build option: define CHANGE_STOCK_EN to keep per-denomination stock
//   counters (refill honoured, err/short possible). Without it stock is
//   infinite, refill is ignored and every request ends in done.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req        change request, sampled in IDLE only
//   i_amount     change owed, captured when i_req is accepted
//   i_coin_ack   mechanism has taken the current coin
//   i_refill     reload stock counters (IDLE only, req has priority)
//   o_coin       coin code being dispensed, 00 when none
//   o_busy       high whenever the FSM is not in IDLE
//   o_done       one-cycle pulse, all change dispensed
//   o_err        one-cycle pulse, exact change impossible
//   o_short      undispensed remainder while o_err=1, otherwise 0
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; refill acted on here
// SELECT | pick the largest coin that fits and is in stock
// SEND   | coin driven, waiting for coin_ack
// DONE   | remainder reached zero, done pulse
// ERR    | no coin fits, err pulse with short = remainder
module change_dispenser #(
  parameter int AMT_W   = 8,
  parameter int STOCK_W = 8,
  parameter int STOCK5  = 10,
  parameter int STOCK2  = 10,
  parameter int STOCK1  = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic [AMT_W-1:0] i_amount,
  input  logic             i_coin_ack,
  input  logic             i_refill,
  output logic [1:0]       o_coin,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [AMT_W-1:0] o_short
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_SEND   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_RS1  = 2'b01;
  localparam logic [1:0] C_RS2  = 2'b10;
  localparam logic [1:0] C_RS5  = 2'b11;

  localparam logic [AMT_W-1:0] V1 = AMT_W'(1);
  localparam logic [AMT_W-1:0] V2 = AMT_W'(2);
  localparam logic [AMT_W-1:0] V5 = AMT_W'(5);

  logic [2:0]       r_state;
  logic [AMT_W-1:0] r_rem;
  logic [1:0]       r_coin;

  logic             w_has5, w_has2, w_has1;
  logic [1:0]       w_pick_code;
  logic             w_pick_ok;
  logic [AMT_W-1:0] w_sent_val;
  logic             w_take;

  // Greedy pick: largest denomination not exceeding the remainder with stock left.
  always_comb begin
    w_pick_code = C_NONE;
    w_pick_ok   = 1'b0;
    if (r_rem >= V5 && w_has5) begin
      w_pick_code = C_RS5;
      w_pick_ok   = 1'b1;
    end else if (r_rem >= V2 && w_has2) begin
      w_pick_code = C_RS2;
      w_pick_ok   = 1'b1;
    end else if (r_rem >= V1 && w_has1) begin
      w_pick_code = C_RS1;
      w_pick_ok   = 1'b1;
    end
  end

  // The coin register still holds the code in SEND, so it doubles as the
  // record of which value to subtract on ack.
  always_comb begin
    case (r_coin)
      C_RS5:   w_sent_val = V5;
      C_RS2:   w_sent_val = V2;
      C_RS1:   w_sent_val = V1;
      default: w_sent_val = '0;
    endcase
  end

  assign w_take = (r_state == S_SEND) && i_coin_ack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_coin  <= C_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_rem   <= i_amount;
            r_state <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (r_rem == '0) begin
            r_state <= S_DONE;
          end else if (w_pick_ok) begin
            r_coin  <= w_pick_code;
            r_state <= S_SEND;
          end else begin
            r_state <= S_ERR;
          end
        end
        S_SEND: begin
          if (i_coin_ack) begin
            r_coin  <= C_NONE;
            r_rem   <= r_rem - w_sent_val;
            r_state <= S_SELECT;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_coin = r_coin;
  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);

`ifdef CHANGE_STOCK_EN
  logic [STOCK_W-1:0] r_stk5, r_stk2, r_stk1;
  logic [AMT_W-1:0]   r_short;

  assign w_has5 = (r_stk5 != '0);
  assign w_has2 = (r_stk2 != '0);
  assign w_has1 = (r_stk1 != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stk5 <= STOCK_W'(STOCK5);
      r_stk2 <= STOCK_W'(STOCK2);
      r_stk1 <= STOCK_W'(STOCK1);
    end else if (r_state == S_IDLE && !i_req && i_refill) begin
      r_stk5 <= STOCK_W'(STOCK5);
      r_stk2 <= STOCK_W'(STOCK2);
      r_stk1 <= STOCK_W'(STOCK1);
    end else if (w_take) begin
      case (r_coin)
        C_RS5:   r_stk5 <= r_stk5 - 1'b1;
        C_RS2:   r_stk2 <= r_stk2 - 1'b1;
        C_RS1:   r_stk1 <= r_stk1 - 1'b1;
        default: ;
      endcase
    end
  end

  // short is loaded on the failing SELECT so it is valid exactly in ERR.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_short <= '0;
    end else if (r_state == S_SELECT && r_rem != '0 && !w_pick_ok) begin
      r_short <= r_rem;
    end else if (r_state == S_ERR) begin
      r_short <= '0;
    end
  end

  assign o_err   = (r_state == S_ERR);
  assign o_short = r_short;
`else
  logic w_unused_refill;

  assign w_has5          = 1'b1;
  assign w_has2          = 1'b1;
  assign w_has1          = 1'b1;
  assign w_unused_refill = i_refill;
  assign o_err           = 1'b0;
  assign o_short         = '0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  localparam int AMT_W   = 8;
  localparam int STOCK_W = 8;
  localparam int S5      = 1;
  localparam int S2      = 3;
  localparam int S1      = 0;

`ifdef CHANGE_STOCK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             req      = 1'b0;
  logic             refill   = 1'b0;
  logic             ack_man  = 1'b0;
  logic             ack_auto = 1'b0;
  logic [AMT_W-1:0] amount   = '0;
  logic             coin_ack;
  logic [1:0]       coin;
  logic             busy, done, err;
  logic [AMT_W-1:0] short_amt;

  assign coin_ack = ack_auto | ack_man;

  change_dispenser #(
    .AMT_W(AMT_W), .STOCK_W(STOCK_W), .STOCK5(S5), .STOCK2(S2), .STOCK1(S1)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_amount(amount),
    .i_coin_ack(coin_ack), .i_refill(refill), .o_coin(coin), .o_busy(busy),
    .o_done(done), .o_err(err), .o_short(short_amt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Scoreboard: coin codes in order, and one end token per request
  // (0 = done, n>0 = err with short n).
  int q_coin[$];
  int q_end[$];
  int ms5, ms2, ms1;

  function automatic bit avail(input int s);
    return !STK || s > 0;
  endfunction

  task automatic model_reload();
    ms5 = S5; ms2 = S2; ms1 = S1;
  endtask

  task automatic model_push(input int amt);
    int r;
    r = amt;
    while (r > 0) begin
      if (r >= 5 && avail(ms5)) begin q_coin.push_back(3); r -= 5; ms5--; end
      else if (r >= 2 && avail(ms2)) begin q_coin.push_back(2); r -= 2; ms2--; end
      else if (r >= 1 && avail(ms1)) begin q_coin.push_back(1); r -= 1; ms1--; end
      else break;
    end
    q_end.push_back(r);
  endtask

  logic [1:0] prev_coin = 2'b00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (coin != 2'b00 && prev_coin == 2'b00) begin
        if (q_coin.size() == 0) chk("coin_extra", int'(coin), 0);
        else chk("coin_seq", int'(coin), q_coin.pop_front());
      end
      if (done || err) begin
        chk("done_err_excl", int'(done & err), 0);
        if (q_end.size() == 0) chk("end_extra", int'({done, err}), 0);
        else chk("end_kind", err ? int'(short_amt) : 0, q_end.pop_front());
      end
      if (!err) chk("short_zero", int'(short_amt), 0);
    end
    prev_coin = coin;
  end

  task automatic start_req(input int amt);
    model_push(amt);
    @(posedge clk); #1;
    req    = 1'b1;
    amount = AMT_W'(amt);
    @(negedge clk);
    chk("busy_pre", int'(busy), 0);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic do_refill();
    @(posedge clk); #1 refill = 1'b1;
    @(posedge clk); #1 refill = 1'b0;
    model_reload();
  endtask

  task automatic wait_coin(input int c, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (int'(coin) == c) hit = 1'b1;
    end
    if (!hit) chk("wait_coin_timeout", int'(coin), c);
  endtask

  task automatic wait_idle(input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (!busy) hit = 1'b1;
    end
    if (!hit) chk("wait_idle_timeout", int'(busy), 0);
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 ack_man = 1'b1;
    @(posedge clk); #1 ack_man = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tl_coin[8];
    int tl_n;
    model_reload();

    // reset state
    @(negedge clk);
    chk("rst_coin", int'(coin), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_short", int'(short_amt), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // amount 8, ack tied high: cycle-exact timeline
`ifdef CHANGE_STOCK_EN
    tl_coin = '{0, 3, 0, 2, 0, 0, 0, 0};
    tl_n    = 6;
`else
    tl_coin = '{0, 3, 0, 2, 0, 1, 0, 0};
    tl_n    = 8;
`endif
    ack_auto = 1'b1;
    start_req(8);
    for (int i = 0; i < tl_n; i++) begin
      @(negedge clk);
      chk("t8_coin", int'(coin), tl_coin[i]);
      chk("t8_busy", int'(busy), 1);
      chk("t8_end", int'(done | err), int'(i == tl_n - 1));
    end
    @(negedge clk);
    chk("t8_idle", int'(busy), 0);

    // amount 0: done two cycles after the req edge, no coin
    do_refill();
    start_req(0);
    @(negedge clk);
    chk("z_done_early", int'(done), 0);
    chk("z_busy", int'(busy), 1);
    @(negedge clk);
    chk("z_done", int'(done), 1);
    chk("z_err", int'(err), 0);
    @(negedge clk);
    chk("z_done_once", int'(done), 0);
    chk("z_idle", int'(busy), 0);

    // amount 7 with ack withheld
    do_refill();
    ack_auto = 1'b0;
    start_req(7);
    wait_coin(3, 10);
    repeat (5) begin
      @(negedge clk);
      chk("hold_coin", int'(coin), 3);
    end
    pulse_ack();
    @(negedge clk);
    chk("post_ack_gap", int'(coin), 0);
    @(negedge clk);
    chk("post_ack_next", int'(coin), 2);
    ack_auto = 1'b1;
    wait_idle(20);

    // shortfall case (err with stock enabled), then a request that completes
    do_refill();
    start_req(6);
    wait_idle(30);
    start_req(4);
    wait_idle(30);

    // req raised during SEND is dropped
    do_refill();
    ack_auto = 1'b0;
    start_req(9);
    wait_coin(3, 10);
    @(posedge clk); #1;
    req    = 1'b1;
    amount = AMT_W'(3);
    repeat (2) @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("req_busy_hold", int'(coin), 3);
    ack_auto = 1'b1;
    wait_idle(30);
    repeat (4) begin
      @(negedge clk);
      chk("req_not_queued", int'(busy), 0);
    end

    // asynchronous reset while a Rs2 coin waits for ack
    do_refill();
    ack_auto = 1'b0;
    start_req(9);
    wait_coin(3, 10);
    pulse_ack();
    wait_coin(2, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_coin", int'(coin), 0);
    chk("arst_busy", int'(busy), 0);
    q_coin.delete();
    q_end.delete();
    model_reload();
    @(posedge clk); #1 rst_n = 1'b1;

    // stock reloaded by reset: 5 must be a single Rs5 coin
    ack_auto = 1'b1;
    start_req(5);
    wait_idle(30);
    repeat (2) @(negedge clk);

    chk("sb_coin_empty", q_coin.size(), 0);
    chk("sb_end_empty", q_end.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
